// File: rtl/tetris_pkg.sv
// Tetris core shared definitions:
// piece encoding and piece generator defaults.
package tetris_pkg;

  localparam int NUM_PIECES = 7;
  localparam int PIECE_W = 3;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [PIECE_W-1:0] {
    PIECE_I = 3'd0,
    PIECE_J = 3'd1,
    PIECE_L = 3'd2,
    PIECE_O = 3'd3,
    PIECE_S = 3'd4,
    PIECE_T = 3'd5,
    PIECE_Z = 3'd6
  } piece_e;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR with seed load.
// A zero seed is replaced by SEED so the state never locks up.
module lfsr_galois #(
  parameter int W = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_val == '0) ? SEED : load_val;
    end else begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/piece_rng_queue.sv
// Piece generator: LFSR rejection sampler, optional
// 7-bag mask and a shift-register preview queue.
module piece_rng_queue
  import tetris_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS = tetris_pkg::LFSR_TAPS,
  parameter logic [LFSR_W-1:0] SEED = tetris_pkg::LFSR_SEED,
  parameter int NUM_PIECES = tetris_pkg::NUM_PIECES,
  parameter int OUT_W = tetris_pkg::PIECE_W,
  parameter int QUEUE_DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic block_new,
  input  logic seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic bag_mode,
  output logic [OUT_W-1:0] piece,
  output logic piece_valid,
  output logic [(QUEUE_DEPTH-1)*OUT_W-1:0] preview,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] queue_count
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);
  localparam int D = QUEUE_DEPTH;
  localparam logic [OUT_W:0] NP = (OUT_W+1)'(NUM_PIECES);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [NUM_PIECES-1:0] ONE = NUM_PIECES'(1);

  logic [LFSR_W-1:0] lfsr;
  logic [OUT_W-1:0] cand;
  logic [NUM_PIECES-1:0] mask_q;
  logic [NUM_PIECES-1:0] mask_eff;
  logic [NUM_PIECES-1:0] mask_set;
  logic [NUM_PIECES-1:0] mask_d;
  logic bag_q;
  logic [OUT_W-1:0] q_q [D];
  logic [OUT_W-1:0] q_d [D];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] wr_idx;
  logic pop;
  logic full;
  logic hit;
  logic accept;
  logic unused_lfsr;

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  assign cand = lfsr[OUT_W-1:0];
  assign unused_lfsr = ^lfsr[LFSR_W-1:OUT_W];

  assign pop = block_new & (count_q != '0);
  assign full = (count_q == FULL);

  // A mode switch wipes the bag before this cycle's draw.
  assign mask_eff = (bag_q != bag_mode) ? '0 : mask_q;
  assign mask_set = ONE << cand;
  assign hit = |(mask_eff & mask_set);

  assign accept = !seed_load
                & ({1'b0, cand} < NP)
                & (!bag_mode | !hit)
                & (!full | pop);

  assign wr_idx = count_q - CW'(pop);

  always_comb begin
    mask_d = mask_eff | (accept ? mask_set : '0);
    if (&mask_d) begin
      mask_d = '0;
    end
  end

  always_comb begin
    q_d = q_q;
    if (pop) begin
      for (int i = 0; i < D-1; i++) begin
        q_d[i] = q_q[i+1];
      end
      q_d[D-1] = '0;
    end
    if (accept) begin
      for (int i = 0; i < D; i++) begin
        if (wr_idx == CW'(i)) begin
          q_d[i] = cand;
        end
      end
    end
    count_d = count_q + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      mask_q <= '0;
      bag_q <= 1'b0;
      for (int i = 0; i < D; i++) begin
        q_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mask_q <= mask_d;
      bag_q <= bag_mode;
      q_q <= q_d;
    end
  end

  assign piece = q_q[0];
  assign piece_valid = (count_q != '0);
  assign queue_count = count_q;

  for (genvar g = 1; g < D; g++) begin : g_prev
    assign preview[(g-1)*OUT_W +: OUT_W] = q_q[g];
  end

endmodule

// File: tb/tb_piece_rng_queue.sv
// Bench for piece_rng_queue: queue-based reference
// model feeding a scoreboard, plus a 5-piece instance.
module tb_piece_rng_queue;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic block_new = 1'b0;
  logic seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0;
  logic bag_mode = 1'b0;
  logic [2:0] piece;
  logic piece_valid;
  logic [5:0] preview;
  logic [1:0] queue_count;

  logic reset5 = 1'b1;
  logic block_new5 = 1'b0;
  logic [2:0] piece5;
  logic piece_valid5;
  logic [5:0] preview5;
  logic [1:0] queue_count5;

  piece_rng_queue dut (
    .clk         (clk),
    .reset       (reset),
    .block_new   (block_new),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .bag_mode    (bag_mode),
    .piece       (piece),
    .piece_valid (piece_valid),
    .preview     (preview),
    .queue_count (queue_count)
  );

  piece_rng_queue #(.NUM_PIECES(5)) dut5 (
    .clk         (clk),
    .reset       (reset5),
    .block_new   (block_new5),
    .seed_load   (1'b0),
    .seed_in     (16'h0),
    .bag_mode    (1'b0),
    .piece       (piece5),
    .piece_valid (piece_valid5),
    .preview     (preview5),
    .queue_count (queue_count5)
  );

  typedef struct {
    logic v;
    logic [1:0] cnt;
    logic [2:0] pc;
    logic [5:0] pv;
    logic [15:0] lf;
    logic [6:0] mk;
    int ph;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr = SEED;
  logic [6:0] m_mask = '0;
  logic m_bag = 1'b0;
  int m_q[$];
  int m_pops = 0;
  int phase = 0;
  bit rec_on = 1'b0;
  int rec[$];

  // Scoreboard monitor: one expected snapshot per clock edge.
  exp_t e;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (piece_valid !== e.v || queue_count !== e.cnt ||
            piece !== e.pc || preview !== e.pv ||
            dut.u_lfsr.state !== e.lf || dut.mask_q !== e.mk) begin
          errors++;
          $display("FAIL state ph=%0d got v=%0b cnt=%0d pc=%0d pv=%h lfsr=%h mask=%h want v=%0b cnt=%0d pc=%0d pv=%h lfsr=%h mask=%h",
                   e.ph, piece_valid, queue_count, piece, preview,
                   dut.u_lfsr.state, dut.mask_q,
                   e.v, e.cnt, e.pc, e.pv, e.lf, e.mk);
        end
      end
      if (rec_on && block_new && piece_valid) begin
        rec.push_back(int'(piece));
      end
    end
  end

  task automatic cyc(input logic rst, input logic bn,
                     input logic sl, input logic [15:0] si,
                     input logic bm);
    logic [2:0] cand;
    logic pop;
    logic acc;
    logic [6:0] msk;
    int d;
    exp_t x;
    @(negedge clk);
    reset = rst;
    block_new = bn;
    seed_load = sl;
    seed_in = si;
    bag_mode = bm;
    if (rst) begin
      m_lfsr = SEED;
      m_q.delete();
      m_mask = '0;
      m_bag = 1'b0;
    end else begin
      cand = m_lfsr[2:0];
      pop = bn && (m_q.size() != 0);
      msk = (m_bag != bm) ? 7'h00 : m_mask;
      acc = !sl && (cand < 3'd7) && (!bm || !msk[cand]) &&
            ((m_q.size() < 3) || pop);
      if (pop) begin
        d = m_q.pop_front();
        m_pops++;
      end
      if (acc) begin
        m_q.push_back(int'(cand));
        msk[cand] = 1'b1;
      end
      if (msk == 7'h7F) msk = 7'h00;
      m_mask = msk;
      m_bag = bm;
      if (sl) m_lfsr = (si == 16'h0) ? SEED : si;
      else m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 16'h0);
    end
    x.v = (m_q.size() != 0);
    x.cnt = 2'(m_q.size());
    x.pc = (m_q.size() > 0) ? 3'(m_q[0]) : 3'd0;
    x.pv[2:0] = (m_q.size() > 1) ? 3'(m_q[1]) : 3'd0;
    x.pv[5:3] = (m_q.size() > 2) ? 3'(m_q[2]) : 3'd0;
    x.lf = m_lfsr;
    x.mk = m_mask;
    x.ph = phase;
    sb.push_back(x);
  endtask

  task automatic fill(input logic bm);
    int n;
    n = 0;
    while (m_q.size() < 3 && n < 60) begin
      cyc(1'b0, 1'b0, 1'b0, 16'h0, bm);
      n++;
    end
    if (m_q.size() < 3) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout ph=%0d got %0d entries want 3",
               phase, m_q.size());
    end
  endtask

  int bits;
  int draws;
  int bad5;
  int n5;

  initial begin
    // Reset hold, release, fill
    phase = 1;
    repeat (8) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    fill(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Single pop from a full queue, then back-to-back pops
    phase = 2;
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Seed loads: zero seed and a plain seed
    phase = 4;
    cyc(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Uniform draws with alternating pops
    phase = 7;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'(i % 2), 1'b0, 16'h0, 1'b0);
    end

    // Pop while empty right after reset
    phase = 5;
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Mode toggling mid-stream
    phase = 8;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'(i % 3 == 0), 1'b0, 16'h0, 1'(i < 5 || i > 7));
    end

    // Bag mode from a clean reset, 14 pops
    phase = 3;
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    rec_on = 1'b1;
    m_pops = 0;
    for (int i = 0; i < 300 && m_pops < 14; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
    end
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    rec_on = 1'b0;
    for (int g = 0; g < 2; g++) begin
      bits = 0;
      for (int k = 0; k < 7; k++) begin
        if (g*7 + k < rec.size()) bits |= 1 << rec[g*7 + k];
      end
      checks++;
      if (bits != 127) begin
        errors++;
        $display("FAIL bag_group%0d got set=%h want set=7f (popped=%0d)",
                 g, bits, rec.size());
      end
    end

    // Reset during a pop with a full queue
    phase = 6;
    fill(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

    // Five-piece instance: 1000 draws stay below 5
    @(negedge clk);
    reset5 = 1'b0;
    block_new5 = 1'b1;
    draws = 0;
    bad5 = 0;
    n5 = 0;
    while (draws < 1000 && n5 < 5000) begin
      @(negedge clk);
      n5++;
      if (piece_valid5) begin
        draws++;
        if (piece5 > 3'd4 || preview5[2:0] > 3'd4 ||
            preview5[5:3] > 3'd4 || queue_count5 > 2'd3) bad5++;
      end
    end
    block_new5 = 1'b0;
    checks++;
    if (bad5 != 0) begin
      errors++;
      $display("FAIL range5 got %0d out-of-range draws want 0", bad5);
    end
    checks++;
    if (draws != 1000) begin
      errors++;
      $display("FAIL draws5 got %0d draws want 1000", draws);
    end

    repeat (3) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
